// File: rtl/eq_serial_ctrl_pkg.sv
// Shared types and helpers for the serial wide-word equality comparator.
// Used by eq_serial_ctrl; the FSM encoding and counter sizing live here.
package eq_serial_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // A single pair still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/eq_serial_ctrl_if.sv
// Start/busy/done handshake and operand bus for eq_serial_ctrl.
// The master issues compares and the controller is the slave.
interface eq_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             aeqb;

    modport master (output start, a, b, input busy, done, aeqb);
    modport slave  (input start, a, b, output busy, done, aeqb);
endinterface

// File: rtl/eq_serial_ctrl_slice2.sv
// Two-bit equality slice: the only compare in the serial datapath.
module eq_slice2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       eq
);
    assign eq = (x == y);
endmodule

// File: rtl/eq_serial_ctrl.sv
// Serial WIDTH-bit equality comparator stepping one 2-bit slice per clock, LSB pair first.
// Define EQ_SERIAL_EARLY_EXIT_EN to finish as soon as a mismatching pair is seen.
module eq_serial_ctrl
    import eq_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    eq_serial_ctrl_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("eq_serial_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [CW-1:0]    cnt_reg;
    logic             match_reg;
    logic             aeqb_reg;

    logic eq;
    logic match_next;
    logic last_pair;

    eq_slice2 u_slice (
        .x  (sa_reg[1:0]),
        .y  (sb_reg[1:0]),
        .eq (eq)
    );

    assign match_next = match_reg & eq;

`ifdef EQ_SERIAL_EARLY_EXIT_EN
    assign last_pair = (cnt_reg == CNT_LAST) || !eq;
`else
    assign last_pair = (cnt_reg == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            cnt_reg   <= '0;
            match_reg <= 1'b1;
            aeqb_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        sa_reg    <= bus.a;
                        sb_reg    <= bus.b;
                        match_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    match_reg <= match_next;
                    sa_reg    <= sa_reg >> 2;
                    sb_reg    <= sb_reg >> 2;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // Result is latched on the edge entering DONE so done and aeqb align.
                    if (last_pair) begin
                        aeqb_reg  <= match_next;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_reg != S_IDLE);
    assign bus.done = (state_reg == S_DONE);
    assign bus.aeqb = aeqb_reg;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Randomised and directed bench for eq_serial_ctrl against a pair-wise reference model.
module tb_eq_serial_ctrl;

    localparam int W = 16;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    eq_serial_ctrl_if #(.WIDTH(W)) bus ();

    eq_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of first differing pair decides early-exit latency.
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int first;
        int lat;
        first = -1;
        for (int k = W / 2 - 1; k >= 0; k--)
            if (x[2*k +: 2] != y[2*k +: 2]) first = k;
        lat = W / 2 + 1;
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        if (first >= 0) lat = first + 2;
`endif
        return lat;
    endfunction

    // Issue one compare from IDLE; returns the edge index at which done is sampled.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input bit chk_hold, input logic hold_val,
                           output int lat, output logic res);
        bus.a = ta;
        bus.b = tb_v;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        lat = -1;
        res = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_cmp++;
                if (bus.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_after_start: got %b want 1", bus.busy);
                end
            end
            if (bus.done === 1'b1) begin
                lat = n;
                res = bus.aeqb;
                break;
            end
            if (chk_hold) begin
                n_cmp++;
                if (bus.aeqb !== hold_val) begin
                    n_bad++;
                    $display("FAIL aeqb_hold: edge %0d got %b want %b", n, bus.aeqb, hold_val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_cmp(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        int   lat;
        logic res;
        run_cmp(ta, tb_v, 1'b0, 1'b0, lat, res);
        $display("cmp %s a=%h b=%h lat=%0d aeqb=%b", name, ta, tb_v, lat, res);
        n_cmp++;
        if (lat !== exp_lat(ta, tb_v)) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(ta, tb_v));
        end
        n_cmp++;
        if (res !== (ta == tb_v)) begin
            n_bad++;
            $display("FAIL %s_aeqb: got %b want %b", name, res, (ta == tb_v));
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_after: busy=%b done=%b want 0 0", name, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #3;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aeqb !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b aeqb=%b want 0 0 0", bus.busy, bus.done, bus.aeqb);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        check_cmp("eq_a5c3", 16'hA5C3, 16'hA5C3);
        check_cmp("msb_diff", 16'h8000, 16'h0000);
        check_cmp("lsb_diff", 16'h0001, 16'h0000);
        check_cmp("all_ones", 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           k;
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            case (i % 3)
                0: rb = ra;
                1: begin
                    k  = $urandom_range(W / 2 - 1, 0);
                    rb = ra ^ (W'($urandom_range(3, 1)) << (2 * k));
                end
                default: rb = W'($urandom);
            endcase
            check_cmp("rand", ra, rb);
        end
    endtask

    task automatic test_back_to_back();
        int   exp_e[$];
        logic exp_r[$];
        int   got_e[$];
        logic got_r[$];
        int   acc;
        int   d;
        logic [W-1:0] av;
        acc = 0;
        while (acc <= 19) begin
            av = (acc <= 3) ? 16'hFFFF : 16'h0000;
            d  = acc + exp_lat(av, 16'hFFFF);
            exp_e.push_back(d);
            exp_r.push_back(av == 16'hFFFF);
            acc = d + 1;
        end
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got_e.push_back(n);
                got_r.push_back(bus.aeqb);
                $display("b2b done edge=%0d aeqb=%b", n, bus.aeqb);
            end
            @(posedge clk); #1;
            if (n == 3) bus.a = 16'h0000;
            if (n == 19) bus.start = 1'b0;
        end
        n_cmp++;
        if (got_e.size() != exp_e.size()) begin
            n_bad++;
            $display("FAIL b2b_pulse_count: got %0d want %0d", got_e.size(), exp_e.size());
        end
        for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
            n_cmp++;
            if (got_e[i] !== exp_e[i] || got_r[i] !== exp_r[i]) begin
                n_bad++;
                $display("FAIL b2b_pulse%0d: got edge %0d aeqb %b want edge %0d aeqb %b",
                         i, got_e[i], got_r[i], exp_e[i], exp_r[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic res;
        check_cmp("pre_rst", 16'h5A5A, 16'h5A5A);
        bus.a = 16'h0F0F;
        bus.b = 16'h0F0F;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aeqb !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: busy=%b done=%b aeqb=%b want 0 0 0", bus.busy, bus.done, bus.aeqb);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_no_done: got %b want 0", bus.done);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, lat, res);
        $display("cmp post_rst a=1234 b=1234 lat=%0d aeqb=%b", lat, res);
        n_cmp++;
        if (res !== 1'b1 || lat !== exp_lat(16'h1234, 16'h1234)) begin
            n_bad++;
            $display("FAIL post_reset_cmp: got aeqb %b lat %0d want 1 %0d", res, lat, exp_lat(16'h1234, 16'h1234));
        end
        @(negedge clk);
    endtask

    task automatic test_aeqb_hold();
        int   lat;
        logic res;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        check_cmp("hold_pre", 16'hC0DE, 16'hC0DE);
        ra = W'($urandom);
        rb = ra ^ W'(16'h4000);
        run_cmp(ra, rb, 1'b1, 1'b1, lat, res);
        $display("cmp hold a=%h b=%h lat=%0d aeqb=%b", ra, rb, lat, res);
        n_cmp++;
        if (res !== 1'b0 || lat !== exp_lat(ra, rb)) begin
            n_bad++;
            $display("FAIL hold_result: got aeqb %b lat %0d want 0 %0d", res, lat, exp_lat(ra, rb));
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_aeqb_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
